// File: rtl/sort_ctrl_if.sv
// Stream bundle for sort_ctrl: input stream, output stream and busy flag.
// slave is the sorter's view; master is the producer/consumer view.
interface sort_ctrl_if #(
  parameter int word_size = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [word_size-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [word_size-1:0] out_data;
  logic                 busy;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/sort_ctrl.sv
// Block bubble sorter: loads DEPTH words, sorts ascending with one shared
// unsigned compare-and-swap per cycle, then drains the sorted block.
module sort_ctrl #(
  parameter int word_size = 16,
  parameter int DEPTH     = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  sort_ctrl_if.slave  sif
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

  state_t               state_q, state_d;
  logic [word_size-1:0] mem_q [DEPTH];
  logic [word_size-1:0] mem_d [DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]        i_q, i_d;
  logic [LW-1:0]        lim_q, lim_d;
  logic                 swapped_q, swapped_d;

  // Shared comparator operands: the adjacent pair at compare index i.
  logic [AW-1:0]        ip1;
  logic [word_size-1:0] cmp_a, cmp_b;
  logic                 gt, sw_now, pass_end;

  assign ip1      = i_q + AW'(1);
  assign cmp_a    = mem_q[i_q];
  assign cmp_b    = mem_q[ip1];
  assign gt       = cmp_a > cmp_b;            // strict: equal words stay put
  assign sw_now   = swapped_q | gt;           // includes this cycle's swap
  assign pass_end = ({1'b0, i_q} == (lim_q - LW'(1)));

  // Handshake/status outputs decode registered state only.
  assign sif.in_ready  = (state_q == LOAD);
  assign sif.out_valid = (state_q == DRAIN);
  assign sif.busy      = (state_q == SORT);
  assign sif.out_data  = mem_q[rd_ptr_q];

  // State and datapath registers; reset clears the whole block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= LOAD;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      i_q       <= '0;
      lim_q     <= LW'(DEPTH - 1);
      swapped_q <= 1'b0;
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      i_q       <= i_d;
      lim_q     <= lim_d;
      swapped_q <= swapped_d;
      mem_q     <= mem_d;
    end
  end

  // Next-state logic for load, compare-and-swap sweep and drain.
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    i_d       = i_q;
    lim_d     = lim_q;
    swapped_d = swapped_q;
    mem_d     = mem_q;
    unique case (state_q)
      LOAD: begin
        if (sif.in_valid) begin
          mem_d[wr_ptr_q] = sif.in_data;
          wr_ptr_d        = wr_ptr_q + AW'(1);
          if (wr_ptr_q == AW'(DEPTH - 1)) begin
            state_d   = SORT;
            wr_ptr_d  = '0;
            i_d       = '0;
            lim_d     = LW'(DEPTH - 1);
            swapped_d = 1'b0;
          end
        end
      end
      SORT: begin
        if (gt) begin
          mem_d[i_q] = cmp_b;
          mem_d[ip1] = cmp_a;
        end
        if (pass_end) begin
          if (!sw_now || lim_q == LW'(1)) begin
            state_d  = DRAIN;
            rd_ptr_d = '0;
          end else begin
            lim_d     = lim_q - LW'(1);
            i_d       = '0;
            swapped_d = 1'b0;
          end
        end else begin
          i_d       = ip1;
          swapped_d = sw_now;
        end
      end
      DRAIN: begin
        if (sif.out_ready) begin
          rd_ptr_d = rd_ptr_q + AW'(1);
          if (rd_ptr_q == AW'(DEPTH - 1)) begin
            state_d  = LOAD;
            rd_ptr_d = '0;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end
endmodule

// File: tb/tb_sort_ctrl.sv
// Self-checking bench for sort_ctrl: directed and random blocks checked
// against a queue-sort reference and a pass-count model of sort duration.
module tb_sort_ctrl;
  localparam int W = 16;
  localparam int D = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sort_ctrl_if #(.word_size(W)) bus ();
  sort_ctrl #(.word_size(W), .DEPTH(D)) dut (.clk(clk), .rst_n(rst_n), .sif(bus.slave));

  int compared   = 0;
  int mismatched = 0;
  bit junk_en    = 1'b0;
  logic [W-1:0] blk [D];
  logic [W-1:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bubble sort with early exit: passes needed = largest count of greater
  // words preceding any word, plus one clean pass unless all DEPTH-1 are used.
  function automatic int model_cycles();
    int k = 0, passes, cyc = 0;
    for (int j = 0; j < D; j++) begin
      int c = 0;
      for (int i = 0; i < j; i++) if (blk[i] > blk[j]) c++;
      if (c > k) k = c;
    end
    passes = (k + 1 > D - 1) ? D - 1 : k + 1;
    for (int p = 0; p < passes; p++) cyc += D - 1 - p;
    return cyc;
  endfunction

  task automatic build_exp();
    exp_q = {};
    for (int k = 0; k < D; k++) exp_q.push_back(blk[k]);
    exp_q.sort();
  endtask

  task automatic rand_blk();
    for (int k = 0; k < D; k++) blk[k] = W'($urandom_range(0, 15) < 4 ? $urandom_range(0, 3) : $urandom);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_out_data", bus.out_data, 0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic load_words(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk("load_in_ready", bus.in_ready, 1);
      bus.in_valid = 1'b1;
      bus.in_data  = blk[k];
    end
    @(posedge clk);
    #1;
    bus.in_valid = (n == D) ? junk_en : 1'b0;
    bus.in_data  = W'($urandom);
  endtask

  // Counts busy cycles; abort_at>0 resets on that SORT cycle instead.
  task automatic do_sort(input int exp_cyc, input int abort_at);
    int bc = 0;
    @(negedge clk);
    while (bus.busy === 1'b1 && bc < 200) begin
      bc++;
      chk("sort_in_ready", bus.in_ready, 0);
      chk("sort_out_valid", bus.out_valid, 0);
      if (junk_en) begin
        bus.in_valid = 1'b1;
        bus.in_data  = W'($urandom);
      end
      if (bc == abort_at) begin
        do_reset();
        return;
      end
      @(negedge clk);
    end
    chk("sort_cycles", bc, exp_cyc);
    chk("sort_done_out_valid", bus.out_valid, 1);
  endtask

  // mode 0: always ready, 1: 1,0,0,1 pattern, 2: random ready.
  task automatic do_drain(input int stop_at, input int mode);
    int n = 0, cyc = 0;
    bit stalled = 1'b0, r;
    logic [W-1:0] prev = '0;
    while (n < D && cyc < 400) begin
      if (n == stop_at) begin
        do_reset();
        return;
      end
      chk("drain_out_valid", bus.out_valid, 1);
      chk("drain_in_ready", bus.in_ready, 0);
      if (stalled) chk("stall_stable", bus.out_data, prev);
      case (mode)
        0:       r = 1'b1;
        1:       r = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: r = bit'($urandom_range(0, 1));
      endcase
      bus.out_ready = r;
      if (junk_en) begin
        bus.in_valid = 1'b1;
        bus.in_data  = W'($urandom);
      end
      if (r) begin
        chk("drain_word", bus.out_data, exp_q[n]);
        n++;
      end
      stalled = !r;
      prev    = bus.out_data;
      @(negedge clk);
      cyc++;
    end
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    chk("drain_count", n, D);
    chk("post_drain_out_valid", bus.out_valid, 0);
    chk("post_drain_in_ready", bus.in_ready, 1);
  endtask

  task automatic run_block(input int exp_cyc, input int mode);
    build_exp();
    load_words(D);
    do_sort(exp_cyc, 0);
    do_drain(D, mode);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    #3;
    chk("init_in_ready", bus.in_ready, 1);
    chk("init_out_valid", bus.out_valid, 0);
    chk("init_busy", bus.busy, 0);
    chk("init_out_data", bus.out_data, 0);
    @(negedge clk) rst_n = 1'b1;

    // Reset during LOAD, then a fresh block.
    rand_blk();
    load_words(3);
    @(negedge clk);
    do_reset();
    rand_blk();
    run_block(model_cycles(), 0);

    // Already sorted.
    for (int k = 0; k < D; k++) blk[k] = W'(k + 1);
    run_block(7, 0);

    // Strictly descending.
    for (int k = 0; k < D; k++) blk[k] = W'(D - k);
    run_block(28, 0);

    // Duplicates and extremes (unsigned ordering of 16'h8000).
    blk = '{16'hFFFF, 16'h0000, 16'h0005, 16'h0005, 16'h8000, 16'h0000, 16'h0001, 16'hFFFF};
    run_block(model_cycles(), 0);

    // Backpressure with junk input during SORT and DRAIN.
    junk_en = 1'b1;
    rand_blk();
    run_block(model_cycles(), 1);
    junk_en = 1'b0;

    // Reset on the 10th SORT cycle of a descending block.
    for (int k = 0; k < D; k++) blk[k] = W'(D - k);
    load_words(D);
    do_sort(28, 10);

    // Reset after three drain transfers.
    rand_blk();
    build_exp();
    load_words(D);
    do_sort(model_cycles(), 0);
    do_drain(3, 0);

    // Next block must be clean.
    rand_blk();
    run_block(model_cycles(), 0);

    // Random blocks with random backpressure and junk.
    for (int b = 0; b < 6; b++) begin
      junk_en = bit'($urandom_range(0, 1));
      rand_blk();
      run_block(model_cycles(), 2);
    end
    junk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/sort_ctrl.md
# sort_ctrl

Iterative sorting sequencer that time-shares a single unsigned magnitude comparator across a small local register buffer. It accepts a block of DEPTH words over a valid/ready input stream, bubble-sorts them in ascending order using one compare-and-swap per cycle, then drains the sorted block over a valid/ready output stream. It sits between a producer and a consumer of word_size-bit samples wherever ordered data (min/max selection, median pick) is needed without replicating comparators.

## Interface
- word_size, 16, data width in bits; values are treated as unsigned.
- DEPTH, 8, words per block; power of two, at least 2.
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  block accepts a word this cycle; high only in LOAD.
- in_data  input  word_size  input word.
- out_valid  output  1  out_data holds a sorted word; high only in DRAIN.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_data  output  word_size  current output word, mem[rd_ptr].
- busy  output  1  high only in SORT.

## Operation
- Storage: mem[0..DEPTH-1], each word_size bits. Pointers wr_ptr, rd_ptr and compare index i are clog2(DEPTH) bits. Pass limit lim is clog2(DEPTH)+1 bits. swapped is a 1-bit flag.
- States: LOAD, SORT and DRAIN. The reset state is LOAD.
- LOAD
  - in_ready=1.
  - On in_valid&in_ready: mem[wr_ptr]<=in_data and wr_ptr increments.
  - On the DEPTH-th accept: go to SORT, with wr_ptr=0, i=0, lim=DEPTH-1 and swapped=0.
- SORT, one compare per cycle:
  - Compare mem[i] against mem[i+1] as unsigned values.
  - If mem[i]>mem[i+1], swap the two words and set swapped. Equal words are never swapped, so the sort is stable.
  - If i<lim-1, i increments.
  - If i==lim-1, the pass ends:
    - If (no swap this pass, including the current cycle) or lim==1: go to DRAIN with rd_ptr=0.
    - Otherwise: lim decrements, i=0 and swapped=0.
- DRAIN
  - out_valid=1 and out_data=mem[rd_ptr].
  - On out_valid&out_ready, rd_ptr increments.
  - On the DEPTH-th transfer: go to LOAD with rd_ptr=0.
  - out_data stays stable while out_valid=1 and out_ready=0.
- Input ignored outside LOAD: in_valid has no effect and nothing is stored.
- out_ready is ignored outside DRAIN.

## Timing
- Reset values, applied immediately on rst_n low regardless of clk:
  - State: LOAD, so in_ready=1.
  - Outputs: out_valid=0, busy=0, out_data=0.
  - Internal: all mem words 0, all pointers 0, lim=DEPTH-1, swapped=0.
- Reset mid-operation in any state aborts the block. Partial load and sort contents are discarded (zeroed) with no output.
- in_ready, out_valid and busy are decoded from the registered state only. There are no combinational paths from in_valid or out_ready to any output.
- The cycle after the DEPTH-th input handshake is the first SORT cycle.
- SORT duration:
  - Already sorted or all-equal block: exactly DEPTH-1 cycles.
  - Worst case (strictly descending): DEPTH*(DEPTH-1)/2 cycles, which is 28 for DEPTH=8.
- The cycle after the last SORT cycle has out_valid=1.
- With out_ready held high, DRAIN lasts exactly DEPTH cycles. LOAD is re-entered on the next cycle.
- Back-to-back blocks: the minimum per-block period is DEPTH + (DEPTH-1) + DEPTH cycles.

## Test plan
- Reset during LOAD:
  - Stimulus: accept 3 words, assert rst_n=0 mid-cycle, release, then load 8 words.
  - Required: in_ready=1 and out_valid=0 immediately on reset. The drained block contains only the 8 new words, sorted.
- Sorted input:
  - Stimulus: load 1,2,3,4,5,6,7,8.
  - Required: busy high for exactly 7 cycles. Output is 1..8 unchanged.
- Descending input:
  - Stimulus: load 8,7,6,5,4,3,2,1.
  - Required: busy high for exactly 28 cycles. Output is 1,2,...,8.
- Duplicates and extremes:
  - Stimulus: load 16'hFFFF,0,5,5,16'h8000,0,1,16'hFFFF.
  - Required output: 0,0,1,5,5,16'h8000,16'hFFFF,16'hFFFF. 16'h8000 must sort as unsigned, above 5.
- Backpressure and ignored input:
  - Stimulus: during DRAIN, toggle out_ready 1,0,0,1,... and drive in_valid=1 with junk data throughout SORT and DRAIN.
  - Required: out_data holds stable while stalled, and there are no duplicate or skipped words. The junk is never stored and in_ready=0 until LOAD.
- Reset during SORT and DRAIN:
  - Stimulus: assert rst_n=0 on the 10th cycle of a descending-input SORT, then again after 3 drain transfers.
  - Required: busy=0 and out_valid=0 immediately. The next block sorts correctly.
